// File: rtl/demux1_4_tdm.sv
// Receive side of the 4:1 TDM mux tree: spreads a slot-tagged sample stream
// over four registered lanes and tracks frame alignment with a hunt/lock FSM.
module demux1_4_tdm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             s0,
  input  logic             s1,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  output logic             frame_done,
  output logic             sync_err,
  output logic             locked
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] lane_q [4];
  logic [WIDTH-1:0] lane_d [4];
  logic [3:0]       out_valid_q, out_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             sync_err_q, sync_err_d;

  logic             wr_en;
  logic [1:0]       wr_lane;

  // Slot decode: decides whether this sample is written, where, and how the
  // framing state moves. Addressed mode bypasses the FSM and freezes it.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    wr_en        = 1'b0;
    wr_lane      = 2'd0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;

    if (in_valid) begin
      if (mode) begin
        wr_en   = 1'b1;
        wr_lane = {s1, s0};
      end else begin
        unique case (state_q)
          HUNT: begin
            if (in_sof) begin
              wr_en   = 1'b1;
              wr_lane = 2'd0;
              slot_d  = 2'd1;
              state_d = LOCKED;
            end
          end
          LOCKED: begin
            if (in_sof) begin
              // An SOF always realigns to slot 0; only mid-frame is an error.
              sync_err_d = (slot_q != 2'd0);
              wr_en      = 1'b1;
              wr_lane    = 2'd0;
              slot_d     = 2'd1;
            end else if (slot_q == 2'd0) begin
              sync_err_d = 1'b1;
              slot_d     = 2'd0;
              state_d    = HUNT;
            end else begin
              wr_en        = 1'b1;
              wr_lane      = slot_q;
              slot_d       = slot_q + 2'd1;
              frame_done_d = (slot_q == 2'd3);
            end
          end
          default: begin
            state_d = HUNT;
            slot_d  = 2'd0;
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_d[i] = lane_q[i];
    end
    out_valid_d = 4'b0000;
    if (wr_en) begin
      lane_d[wr_lane]      = in_data;
      out_valid_d[wr_lane] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      slot_q       <= 2'd0;
      out_valid_q  <= 4'b0000;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= lane_d[i];
      end
    end
  end

  assign out0       = lane_q[0];
  assign out1       = lane_q[1];
  assign out2       = lane_q[2];
  assign out3       = lane_q[3];
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == LOCKED);

endmodule

// File: doc/demux1_4_tdm.md
# demux1_4_tdm

Time-division 1-to-4 demultiplexer: the receive end of the team's 4:1 mux tree. It takes one serialized sample stream, slot-tagged by a start-of-frame marker or an explicit 2-bit select, and distributes each sample into one of four registered output lanes with per-lane valid pulses. It tracks frame alignment with a small hunt/lock state machine and flags framing errors. It sits after any 4:1 mux-based serializer, restoring the four parallel channels.

## Interface
Parameters:
- WIDTH, 8, sample width in bits (≥1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- mode  input  1  0 = TDM (slot from internal counter), 1 = addressed (slot from s1:s0)
- s0  input  1  select LSB (addressed mode only)
- s1  input  1  select MSB (addressed mode only)
- in_valid  input  1  sample present this cycle
- in_sof  input  1  sample is slot 0 of a frame (TDM mode only)
- in_data  input  WIDTH  sample
- out0..out3  output  WIDTH each  lane data registers
- out_valid  output  4  one-hot, 1-cycle pulse: lane written this cycle
- frame_done  output  1  1-cycle pulse: slot 3 written in TDM mode
- sync_err  output  1  1-cycle pulse: framing violation detected
- locked  output  1  high in LOCKED state

## Operation
- Reset (async, immediate): out0..out3 = 0, out_valid = 0, frame_done = 0, sync_err = 0, locked = 0, state = HUNT, slot = 0.
- Addressed mode (mode=1): each in_valid cycle writes in_data to lane {s1,s0}; in_sof ignored; state, slot and locked hold their values; frame_done and sync_err stay 0.
- TDM mode (mode=0), states:
  - HUNT: in_valid without in_sof → sample dropped, no output. in_valid with in_sof → write lane 0, slot←1, go LOCKED.
  - LOCKED: in_valid with slot≠0 and in_sof=0 → write lane slot, slot←slot+1 mod 4. On slot 3 write, also pulse frame_done.
  - LOCKED, in_valid, in_sof=1, slot≠0 (early SOF) → pulse sync_err, treat sample as slot 0: write lane 0, slot←1, stay LOCKED.
  - LOCKED, in_valid, in_sof=0, slot=0 (missing SOF) → pulse sync_err, drop sample, slot←0, go HUNT.
  - LOCKED, in_valid, in_sof=1, slot=0 → normal slot-0 write, slot←1.
- in_valid=0: no state, slot or lane change; all pulses 0.
- Lanes not written hold their previous value; only the written lane updates.
- Mode change takes effect on the next sample. Switching 1→0 does not reset state or slot. Switching 0→1 freezes them.

## Timing
- Latency 1 cycle: sample at edge N appears on outK, with out_valid[K]=1, after edge N.
- out_valid, frame_done and sync_err are registered. Each is high for exactly one cycle per causing sample, and 0 otherwise.
- frame_done coincides with out_valid[3]. sync_err coincides with the cycle after the offending sample: with out_valid[0] for early SOF, with out_valid=0 for missing SOF.
- locked rises in the cycle lane 0 is first written and falls in the cycle sync_err reports a missing SOF.
- Back-to-back in_valid every cycle is supported at full rate. Gaps of any length are allowed and do not advance slot.
- Reset asserted mid-frame clears everything asynchronously. After release, the block is in HUNT and the first SOF is required.

## Test plan
- Reset with WIDTH=8: assert rst mid-stream → all outputs 0 and locked=0 immediately; after release, samples 0x11, 0x22 without SOF → no out_valid.
- TDM, continuous valid: SOF+0xA0, 0xA1, 0xA2, 0xA3 → out0..out3 = A0..A3 on successive cycles; out_valid sequence 0001, 0010, 0100, 1000; frame_done with the last; locked=1 from the first.
- Gapped stream: same frame with 2 idle cycles between samples → identical lane values; no pulses during gaps; slot does not advance.
- Early SOF: SOF+0x10, 0x11, SOF+0x20 → sync_err pulse, out0=0x20, out1 keeps 0x11, locked stays 1; next 0x21 → out1.
- Missing SOF: full frame 0x30–0x33, then 0x40 without SOF → sync_err, no lane written, locked=0; then SOF+0x50 → out0=0x50, locked=1.
- Addressed mode: mode=1, {s1,s0}=2 with 0x7E, then 0 with 0x01 → out2=0x7E, then out0=0x01; frame_done=0, sync_err=0, locked unchanged.
